// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Definitions shared by the VGA picture path: screen and sprite geometry,
// the sprite mover state enum, and the per-axis direction code with the
// helper that derives it from a pair of opposing buttons.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VALID = 640;   // active pixels per line
    localparam int V_VALID = 480;   // active lines per frame
    localparam int PIC_W   = 100;   // sprite width
    localparam int PIC_H   = 100;   // sprite height

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_e;

    // Direction of travel along one axis.
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10
    } dir_e;

    // Opposing buttons cancel: both held or neither held means no motion.
    function automatic dir_e net_dir(input logic pos_btn, input logic neg_btn);
        dir_e d;
        case ({pos_btn, neg_btn})
            2'b10:   d = DIR_POS;
            2'b01:   d = DIR_NEG;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/axis_step_clamp.sv
// ---------------------------------------------------------------------------
// axis_step_clamp
// Next position along one axis: moves pos_i by step_i in direction dir_i and
// clamps the result to [0, max_i].  Arithmetic carries one extra bit so an
// increment past max_i is detected instead of wrapping.
//   pos_i   current position
//   dir_i   DIR_POS / DIR_NEG / DIR_NONE
//   step_i  pixels to move
//   max_i   largest legal position
//   next_o  clamped next position (combinational)
// ---------------------------------------------------------------------------
module axis_step_clamp
    import vga_pkg::*;
#(
    parameter int POS_W = 10
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic [1:0]       dir_i,
    input  logic [POS_W-1:0] step_i,
    input  logic [POS_W-1:0] max_i,
    output logic [POS_W-1:0] next_o
);

    logic [POS_W:0] sum_s;

    assign sum_s = {1'b0, pos_i} + {1'b0, step_i};

    // Step and clamp according to direction.
    always_comb begin
        next_o = pos_i;
        case (dir_i)
            DIR_POS: begin
                if (sum_s > {1'b0, max_i}) begin
                    next_o = max_i;
                end else begin
                    next_o = sum_s[POS_W-1:0];
                end
            end
            DIR_NEG: begin
                if (pos_i < step_i) begin
                    next_o = {POS_W{1'b0}};
                end else begin
                    next_o = pos_i - step_i;
                end
            end
            default: next_o = pos_i;
        endcase
    end

endmodule

// File: rtl/sprite_move_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_move_ctrl
// Per-frame sprite position controller.  Buttons are synchronized into the
// pixel clock domain; the sprite position, acceleration counter and IDLE/MOVE
// state change only on the last active pixel of each frame so the picture
// never tears.  Movement accelerates while any direction is held and is
// clamped so the sprite stays entirely on screen.
// Ports:
//   vga_clk, sys_rst        pixel clock, asynchronous active-high reset
//   pix_x, pix_y            current pixel from the timing generator
//   btn_up/down/left/right  direction buttons (asynchronous)
//   btn_home                return to centre (asynchronous)
//   x_move, y_move          registered sprite top-left corner
//   frame_tick              one-cycle pulse with each position update
//   moving                  high while in MOVE
// ---------------------------------------------------------------------------
module sprite_move_ctrl
    import vga_pkg::*;
#(
    parameter int H_VALID      = vga_pkg::H_VALID,
    parameter int V_VALID      = vga_pkg::V_VALID,
    parameter int PIC_W        = vga_pkg::PIC_W,
    parameter int PIC_H        = vga_pkg::PIC_H,
    parameter int HOME_X       = (H_VALID - PIC_W) / 2,
    parameter int HOME_Y       = (V_VALID - PIC_H) / 2,
    parameter int MAX_STEP     = 4,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_home,
    output logic [9:0]  x_move,
    output logic [9:0]  y_move,
    output logic        frame_tick,
    output logic        moving
);

    localparam int X_MAX    = H_VALID - PIC_W;
    localparam int Y_MAX    = V_VALID - PIC_H;
    localparam int HOLD_MAX = (MAX_STEP - 1) * ACCEL_FRAMES;
    localparam int HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    // ACCEL_FRAMES is a power of two, so the divide is a shift.
    localparam int ACCEL_SH = $clog2(ACCEL_FRAMES);

    // Synchronizer bit order: {home, right, left, down, up}.
    logic [4:0]        btn_meta_q;
    logic [4:0]        btn_sync_q;

    state_e            state_q;
    logic [9:0]        x_q;
    logic [9:0]        y_q;
    logic [HOLD_W-1:0] hold_q;
    logic              frame_tick_q;
    logic              moving_q;

    logic              tick_s;
    logic              home_s;
    logic [1:0]        dir_x_s;
    logic [1:0]        dir_y_s;
    logic              any_dir_s;
    logic [9:0]        step_s;
    logic [HOLD_W-1:0] hold_inc_s;
    logic [9:0]        x_next_s;
    logic [9:0]        y_next_s;

    // Two-flop synchronizers for all five buttons.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            btn_meta_q <= 5'b00000;
            btn_sync_q <= 5'b00000;
        end else begin
            btn_meta_q <= {btn_home, btn_right, btn_left, btn_down, btn_up};
            btn_sync_q <= btn_meta_q;
        end
    end

    // Last active pixel of the frame is the single update point.
    assign tick_s = (pix_x == 12'(H_VALID - 1)) && (pix_y == 12'(V_VALID - 1));

    assign home_s    = btn_sync_q[4];
    assign dir_x_s   = net_dir(btn_sync_q[3], btn_sync_q[2]);
    assign dir_y_s   = net_dir(btn_sync_q[1], btn_sync_q[0]);
    // A cancelled axis still counts as held when the other axis moves.
    assign any_dir_s = (dir_x_s != DIR_NONE) || (dir_y_s != DIR_NONE);

    // Step uses the counter value from before this tick.
    assign step_s     = 10'd1 + 10'(hold_q >> ACCEL_SH);
    assign hold_inc_s = (hold_q == HOLD_W'(HOLD_MAX)) ? hold_q : hold_q + HOLD_W'(1);

    axis_step_clamp #(.POS_W(10)) u_x_axis (
        .pos_i  (x_q),
        .dir_i  (dir_x_s),
        .step_i (step_s),
        .max_i  (10'(X_MAX)),
        .next_o (x_next_s)
    );

    axis_step_clamp #(.POS_W(10)) u_y_axis (
        .pos_i  (y_q),
        .dir_i  (dir_y_s),
        .step_i (step_s),
        .max_i  (10'(Y_MAX)),
        .next_o (y_next_s)
    );

    // Mover FSM with position, acceleration counter and registered outputs.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            x_q          <= 10'(HOME_X);
            y_q          <= 10'(HOME_Y);
            hold_q       <= HOLD_W'(0);
            frame_tick_q <= 1'b0;
            moving_q     <= 1'b0;
        end else begin
            frame_tick_q <= tick_s;
            if (tick_s) begin
                case (state_q)
                    IDLE: begin
                        if (!home_s && any_dir_s) begin
                            state_q <= MOVE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    MOVE: begin
                        if (home_s || !any_dir_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= MOVE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                // Home wins over any direction.
                if (home_s) begin
                    x_q      <= 10'(HOME_X);
                    y_q      <= 10'(HOME_Y);
                    hold_q   <= HOLD_W'(0);
                    moving_q <= 1'b0;
                end else if (any_dir_s) begin
                    x_q      <= x_next_s;
                    y_q      <= y_next_s;
                    hold_q   <= hold_inc_s;
                    moving_q <= 1'b1;
                end else begin
                    hold_q   <= HOLD_W'(0);
                    moving_q <= 1'b0;
                end
            end
        end
    end

    assign x_move     = x_q;
    assign y_move     = y_q;
    assign frame_tick = frame_tick_q;
    assign moving     = moving_q;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_move_ctrl
// Self-checking bench.  pix_x/pix_y are driven directly so a "frame" costs
// only a few cycles: the tick coordinate is presented for one cycle after the
// buttons have been stable long enough to pass the synchronizers.  A
// behavioural model tracks position, held-frame count and moving.
// ---------------------------------------------------------------------------
module tb_sprite_move_ctrl;

    // Button vector order: {home, right, left, down, up}.
    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_HOME  = 5'b10000;

    logic        vga_clk = 1'b0;
    logic        sys_rst;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        btn_up, btn_down, btn_left, btn_right, btn_home;
    logic [9:0]  x_move, y_move;
    logic        frame_tick, moving;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int   mx, my, mh;
    logic mmov;

    sprite_move_ctrl dut (
        .vga_clk    (vga_clk),
        .sys_rst    (sys_rst),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_home   (btn_home),
        .x_move     (x_move),
        .y_move     (y_move),
        .frame_tick (frame_tick),
        .moving     (moving)
    );

    always #20 vga_clk = ~vga_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btn_home, btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic model_reset();
        mx = 270; my = 190; mh = 0; mmov = 1'b0;
    endtask

    // Frame update from the rules: home, else move by 1 + held/8 and clamp,
    // else stop and forget acceleration.
    task automatic model_tick(input logic [4:0] b);
        int dx, dy, st;
        if (b[4]) begin
            model_reset();
        end else begin
            dx = int'(b[3]) - int'(b[2]);
            dy = int'(b[1]) - int'(b[0]);
            if (dx != 0 || dy != 0) begin
                st = 1 + mh / 8;
                mx = mx + dx * st;
                my = my + dy * st;
                if (mx < 0)   mx = 0;
                if (mx > 540) mx = 540;
                if (my < 0)   my = 0;
                if (my > 380) my = 380;
                mh = (mh + 1 > 24) ? 24 : mh + 1;
                mmov = 1'b1;
            end else begin
                mh = 0;
                mmov = 1'b0;
            end
        end
    endtask

    // Hold buttons for pre cycles off-tick, then present one tick cycle.
    // Returns just after the update edge.
    task automatic run_frame(input logic [4:0] b, input int pre);
        set_btns(b);
        pix_x = 12'd100; pix_y = 12'd100;
        cyc(pre);
        pix_x = 12'd639; pix_y = 12'd479;
        cyc(1);
        pix_x = 12'd0; pix_y = 12'd0;
        model_tick(b);
    endtask

    // Steer the model (and DUT) to a target using steps that never overshoot.
    task automatic goto_pos(input int tx, input int ty);
        int st;
        logic [4:0] b;
        for (int i = 0; i < 3000; i++) begin
            if (mx == tx && my == ty) break;
            st = 1 + mh / 8;
            b = B_NONE;
            if (tx - mx >= st)      b = b | B_RIGHT;
            else if (mx - tx >= st) b = b | B_LEFT;
            if (ty - my >= st)      b = b | B_DOWN;
            else if (my - ty >= st) b = b | B_UP;
            run_frame(b, 3);
        end
        run_frame(B_NONE, 3);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        pix_x = 12'd0; pix_y = 12'd0;
        set_btns(B_NONE);
        cyc(3);
        n_checks++; if (x_move !== 10'd270) begin n_fail++; $display("FAIL reset_x: got %0d expected 270", x_move); end
        n_checks++; if (y_move !== 10'd190) begin n_fail++; $display("FAIL reset_y: got %0d expected 190", y_move); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b expected 0", moving); end
        n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
        sys_rst = 1'b0;
        model_reset();
        cyc(2);
    endtask

    task automatic test_right_30();
        int pulses = 0;
        run_frame(B_NONE, 3);
        for (int i = 0; i < 30; i++) begin
            run_frame(B_RIGHT, 3 + (i % 4));
            if (frame_tick === 1'b1) pulses++;
            n_checks++; if (x_move !== 10'(mx)) begin n_fail++; $display("FAIL right30_x[%0d]: got %0d expected %0d", i, x_move, mx); end
            n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL right30_moving[%0d]: got %b expected 1", i, moving); end
            cyc(1);
            n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL right30_tick_width[%0d]: got %b expected 0", i, frame_tick); end
        end
        n_checks++; if (pulses != 30) begin n_fail++; $display("FAIL right30_pulses: got %0d expected 30", pulses); end
        n_checks++; if (x_move !== 10'd342) begin n_fail++; $display("FAIL right30_final_x: got %0d expected 342", x_move); end
        n_checks++; if (y_move !== 10'd190) begin n_fail++; $display("FAIL right30_final_y: got %0d expected 190", y_move); end
    endtask

    task automatic test_clamp_right();
        goto_pos(538, my);
        n_checks++; if (x_move !== 10'd538) begin n_fail++; $display("FAIL clampr_start: got %0d expected 538", x_move); end
        for (int i = 0; i < 6; i++) begin
            run_frame(B_RIGHT, 3);
            n_checks++; if (x_move !== 10'(mx)) begin n_fail++; $display("FAIL clampr_x[%0d]: got %0d expected %0d", i, x_move, mx); end
        end
        n_checks++; if (x_move !== 10'd540) begin n_fail++; $display("FAIL clampr_final: got %0d expected 540", x_move); end
    endtask

    task automatic test_clamp_left();
        goto_pos(2, 190);
        // Build full acceleration on y alone, then switch to left at step 4.
        for (int i = 0; i < 24; i++) run_frame(B_DOWN, 3);
        n_checks++; if (x_move !== 10'd2) begin n_fail++; $display("FAIL clampl_start: got %0d expected 2", x_move); end
        n_checks++; if (y_move !== 10'(my)) begin n_fail++; $display("FAIL clampl_y: got %0d expected %0d", y_move, my); end
        run_frame(B_LEFT, 3);
        n_checks++; if (x_move !== 10'd0) begin n_fail++; $display("FAIL clampl_x: got %0d expected 0", x_move); end
        run_frame(B_LEFT, 4);
        n_checks++; if (x_move !== 10'd0) begin n_fail++; $display("FAIL clampl_stay: got %0d expected 0", x_move); end
    endtask

    task automatic test_opposing();
        int x0;
        run_frame(B_NONE, 3);
        x0 = mx;
        for (int i = 0; i < 10; i++) begin
            run_frame(B_LEFT | B_RIGHT | B_DOWN, 3);
            n_checks++; if (x_move !== 10'(x0)) begin n_fail++; $display("FAIL opp_x[%0d]: got %0d expected %0d", i, x_move, x0); end
            n_checks++; if (y_move !== 10'(my)) begin n_fail++; $display("FAIL opp_y[%0d]: got %0d expected %0d", i, y_move, my); end
            n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL opp_moving[%0d]: got %b expected 1", i, moving); end
        end
    endtask

    task automatic test_home();
        goto_pos(376, 300);
        for (int i = 0; i < 16; i++) run_frame(B_RIGHT, 3);
        n_checks++; if (x_move !== 10'd400 || y_move !== 10'd300) begin n_fail++; $display("FAIL home_pre: got (%0d,%0d) expected (400,300)", x_move, y_move); end
        run_frame(B_HOME | B_RIGHT, 3);
        n_checks++; if (x_move !== 10'd270 || y_move !== 10'd190) begin n_fail++; $display("FAIL home_pos: got (%0d,%0d) expected (270,190)", x_move, y_move); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL home_moving: got %b expected 0", moving); end
        run_frame(B_RIGHT, 3);
        n_checks++; if (x_move !== 10'd271) begin n_fail++; $display("FAIL home_restart: got %0d expected 271", x_move); end
        run_frame(B_NONE, 3);
    endtask

    task automatic test_pulse();
        int x0, y0;
        run_frame(B_NONE, 3);
        x0 = mx; y0 = my;
        pix_x = 12'd200; pix_y = 12'd50;
        set_btns(B_RIGHT);
        cyc(10);
        set_btns(B_NONE);
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL pulse_moving_mid: got %b expected 0", moving); end
        cyc(5);
        run_frame(B_NONE, 3);
        n_checks++; if (x_move !== 10'(x0) || y_move !== 10'(y0)) begin n_fail++; $display("FAIL pulse_pos: got (%0d,%0d) expected (%0d,%0d)", x_move, y_move, x0, y0); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL pulse_moving: got %b expected 0", moving); end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) run_frame(B_RIGHT | B_UP, 3);
        set_btns(B_RIGHT);
        pix_x = 12'd320; pix_y = 12'd240;
        cyc(4);
        sys_rst = 1'b1;
        #1;
        n_checks++; if (x_move !== 10'd270 || y_move !== 10'd190) begin n_fail++; $display("FAIL midrst_pos: got (%0d,%0d) expected (270,190)", x_move, y_move); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL midrst_moving: got %b expected 0", moving); end
        cyc(2);
        sys_rst = 1'b0;
        model_reset();
        run_frame(B_RIGHT, 3);
        n_checks++; if (x_move !== 10'd271) begin n_fail++; $display("FAIL midrst_first_tick: got %0d expected 271", x_move); end
        n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL midrst_first_moving: got %b expected 1", moving); end
    endtask

    task automatic test_random();
        logic [4:0] b;
        for (int i = 0; i < 80; i++) begin
            b = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) b = b | B_HOME;
            run_frame(b, int'($urandom_range(3, 9)));
            n_checks++; if (x_move !== 10'(mx) || y_move !== 10'(my)) begin n_fail++; $display("FAIL rand_pos[%0d]: btn=%b got (%0d,%0d) expected (%0d,%0d)", i, b, x_move, y_move, mx, my); end
            n_checks++; if (moving !== mmov) begin n_fail++; $display("FAIL rand_moving[%0d]: got %b expected %b", i, moving, mmov); end
            n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL rand_tick[%0d]: got %b expected 1", i, frame_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_right_30();
        test_clamp_right();
        test_clamp_left();
        test_opposing();
        test_home();
        test_pulse();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
